alu_issue_sched: RTL

//  Issue scheduler for the shared execute-stage ALU. Picks one ready reservation-station

---
 rtl/alu_sched_pkg.sv | 22 ++
 rtl/alu_issue_sched_rr_arbiter.sv | 38 +++
 rtl/alu_issue_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU issue scheduler: state encoding, op code
// for multiply, default parameter values and a saturating-increment helper.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE    = 2'b00,
        SCHED_MUL     = 2'b01,
        SCHED_WB_HOLD = 2'b10
    } sched_state_e;

    localparam logic [1:0] OP_MUL = 2'b01;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TAG_W   = 6;
    localparam int DEF_MUL_LAT = 3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/alu_issue_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr (wrapping). Outputs are all-zero when en is low or nothing is requested.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] win;
    int            cand;

    // Scan candidates in priority order starting from ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    assign grant_idx = (en && found) ? win : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign grant[gi] = en && found && (win == IW'(gi));
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Issue scheduler for the shared execute-stage ALU. Grants one ready
// reservation-station entry per cycle (round robin), holds the ALU for the
// duration of a multiply, and holds the result tag until the CDB accepts it.
// Optional feature macro: ALU_SCHED_PERF_EN adds saturating perf counters
// (perf_issued, perf_mul_busy, perf_wb_stall).
module alu_issue_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         rs_valid,
    input  logic [NUM_REQ-1:0]         rs_is_mul,
    input  logic [NUM_REQ*TAG_W-1:0]   rs_tag,
    output logic [NUM_REQ-1:0]         rs_grant,
    output logic [$clog2(NUM_REQ)-1:0] sel_idx,
    output logic                       req_ex,
    output logic                       wb_valid,
    output logic [TAG_W-1:0]           wb_tag,
    input  logic                       wb_ready
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_issued,
    output logic [31:0]                perf_mul_busy,
    output logic [31:0]                perf_wb_stall
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MUL_LAT);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

    logic             can_grant;
    logic             grant_any;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic [TAG_W-1:0] tag_arr [NUM_REQ];
    logic [TAG_W-1:0] win_tag;
    logic             win_is_mul;
    logic [1:0]       win_op;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_tag_unpack
        assign tag_arr[gi] = rs_tag[gi*TAG_W +: TAG_W];
    end

    // A new op may start when the ALU is free, or when the held result is
    // leaving this cycle. Flush and reset suppress any grant.
    always_comb begin
        can_grant = !reset && !flush &&
                    ((state_q == SCHED_IDLE) ||
                     ((state_q == SCHED_WB_HOLD) && wb_ready));
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req       (rs_valid),
        .ptr       (rr_ptr_q),
        .en        (can_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign grant_any  = |arb_grant;
    assign win_tag    = tag_arr[arb_idx];
    assign win_is_mul = rs_is_mul[arb_idx];

    assign rs_grant = arb_grant;
    assign sel_idx  = arb_idx;
    assign req_ex   = grant_any || (state_q == SCHED_MUL);
    assign wb_valid = (state_q == SCHED_WB_HOLD);
    assign wb_tag   = wb_tag_q;

    // Next-state logic: retire/countdown the current op, then let a new grant
    // override the destination state (back-to-back issue). Flush wins.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        busy_cnt_d = busy_cnt_q;
        wb_tag_d   = wb_tag_q;
        win_op     = win_is_mul ? OP_MUL : 2'b00;

        if (flush) begin
            state_d    = SCHED_IDLE;
            busy_cnt_d = '0;
        end else begin
            unique case (state_q)
                SCHED_IDLE: ;
                SCHED_MUL: begin
                    busy_cnt_d = busy_cnt_q - CNT_W'(1);
                    if (busy_cnt_q == CNT_W'(1)) begin
                        state_d = SCHED_WB_HOLD;
                    end
                end
                SCHED_WB_HOLD: begin
                    if (wb_ready) begin
                        state_d = SCHED_IDLE;
                    end
                end
                default: begin
                    state_d    = SCHED_IDLE;
                    busy_cnt_d = '0;
                end
            endcase

            if (grant_any) begin
                wb_tag_d = win_tag;
                rr_ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                if (win_op == OP_MUL) begin
                    state_d    = SCHED_MUL;
                    busy_cnt_d = CNT_W'(MUL_LAT - 1);
                end else begin
                    state_d = SCHED_WB_HOLD;
                end
            end
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCHED_IDLE;
            rr_ptr_q   <= '0;
            busy_cnt_q <= '0;
            wb_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_cnt_q <= busy_cnt_d;
            wb_tag_q   <= wb_tag_d;
        end
    end

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_mul_busy_q, perf_mul_busy_d;
    logic [31:0] perf_wb_stall_q, perf_wb_stall_d;

    // Counter increments: grants, cycles spent multiplying, CDB back-pressure.
    always_comb begin
        perf_issued_d   = grant_any ? sat_inc(perf_issued_q) : perf_issued_q;
        perf_mul_busy_d = (state_q == SCHED_MUL) ? sat_inc(perf_mul_busy_q) : perf_mul_busy_q;
        perf_wb_stall_d = (wb_valid && !wb_ready) ? sat_inc(perf_wb_stall_q) : perf_wb_stall_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q   <= '0;
            perf_mul_busy_q <= '0;
            perf_wb_stall_q <= '0;
        end else begin
            perf_issued_q   <= perf_issued_d;
            perf_mul_busy_q <= perf_mul_busy_d;
            perf_wb_stall_q <= perf_wb_stall_d;
        end
    end

    assign perf_issued   = perf_issued_q;
    assign perf_mul_busy = perf_mul_busy_q;
    assign perf_wb_stall = perf_wb_stall_q;
`endif

endmodule
